// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction RAM write port of the program loader.
// The loader is the slave end; the byte source / RAM model is the master end.
interface instr_loader_if #(
    parameter int addr_w      = 8,
    parameter int instr_width = 9
);
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   wr_en;
    logic [addr_w-1:0]      wr_addr;
    logic [instr_width-1:0] wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: packs byte pairs into instruction words, writes them from address 0.
// Define CHECKSUM_EN to require a trailing XOR checksum byte after the halt word.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_LO    | waiting for the low byte of a word
// S_HI    | waiting for the high byte of a word
// S_WRITE | wr_en high for one cycle, then decide halt/overflow/continue
// S_CHK   | waiting for the checksum byte (CHECKSUM_EN only)
// S_DONE  | load finished, done/error held until start
module instr_loader #(
    parameter int                     rom_size    = 256,
    parameter int                     instr_width = 9,
    parameter logic [instr_width-1:0] halt_word   = 9'b111000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    instr_loader_if.slave             bus,
    output logic [$clog2(rom_size):0] word_count,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int               addr_w     = $clog2(rom_size);
    localparam logic [addr_w:0] full_count = (addr_w + 1)'(rom_size);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
`ifdef CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t                 state;
    logic [7:0]             word_lo;
    logic                   wr_en_q;
    logic [addr_w-1:0]      wr_addr_q;
    logic [instr_width-1:0] wr_data_q;
    logic                   ready_c;
    logic                   take;
    logic [addr_w:0]        count_next;
`ifdef CHECKSUM_EN
    logic [7:0]             csum;
`endif

    always_comb begin
        ready_c = (state == S_LO) || (state == S_HI);
`ifdef CHECKSUM_EN
        if (state == S_CHK) ready_c = 1'b1;
`endif
    end

    assign take           = bus.byte_valid && ready_c;
    assign count_next     = word_count + 1'b1;
    assign bus.byte_ready = ready_c;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            word_lo    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LO;
                        wr_addr_q  <= '0;
                        word_count <= '0;
                        error      <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
`ifdef CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                S_LO: begin
                    if (take) begin
                        word_lo <= bus.byte_in;
                        state   <= S_HI;
`ifdef CHECKSUM_EN
                        csum    <= csum ^ bus.byte_in;
`endif
                    end
                end
                S_HI: begin
                    if (take) begin
                        // upper bits of the high byte beyond instr_width are dropped
                        wr_data_q <= {bus.byte_in[instr_width-9:0], word_lo};
                        wr_addr_q <= word_count[addr_w-1:0];
                        wr_en_q   <= 1'b1;
                        state     <= S_WRITE;
`ifdef CHECKSUM_EN
                        csum      <= csum ^ bus.byte_in;
`endif
                    end
                end
                S_WRITE: begin
                    word_count <= count_next;
                    if (wr_data_q == halt_word) begin
`ifdef CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b0;
`endif
                    end else if (count_next == full_count) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        state <= S_LO;
                    end
                end
`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (take) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= (bus.byte_in != csum);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a 256-word and a 4-word instance share one
// byte source; writes are scoreboarded against a word-level model of the load rules.
module tb_instr_loader;
    localparam logic [8:0] halt = 9'h1C0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n    = 1'b0;
    logic       start_a    = 1'b0;
    logic       start_b    = 1'b0;
    logic       sel        = 1'b0;
    logic [7:0] byte_in    = 8'h00;
    logic       byte_valid = 1'b0;
    int         n_assert   = 0;
    int         n_fail     = 0;

    instr_loader_if #(.addr_w(8), .instr_width(9)) if_a ();
    instr_loader_if #(.addr_w(2), .instr_width(9)) if_b ();

    logic [8:0] wc_a;
    logic [2:0] wc_b;
    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;

    assign if_a.byte_in    = byte_in;
    assign if_a.byte_valid = byte_valid;
    assign if_b.byte_in    = byte_in;
    assign if_b.byte_valid = byte_valid;

    instr_loader #(.rom_size(256), .instr_width(9)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .bus(if_a),
        .word_count(wc_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    instr_loader #(.rom_size(4), .instr_width(9)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .bus(if_b),
        .word_count(wc_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // observed view of whichever instance is under test
    logic       o_ready, o_wr_en, o_busy, o_done, o_err;
    logic [7:0] o_addr;
    logic [8:0] o_data, o_count;

    always_comb begin
        if (sel) begin
            o_ready = if_b.byte_ready; o_wr_en = if_b.wr_en;
            o_addr  = {6'd0, if_b.wr_addr}; o_data = if_b.wr_data;
            o_count = {6'd0, wc_b}; o_busy = busy_b; o_done = done_b; o_err = err_b;
        end else begin
            o_ready = if_a.byte_ready; o_wr_en = if_a.wr_en;
            o_addr  = if_a.wr_addr; o_data = if_a.wr_data;
            o_count = wc_a; o_busy = busy_a; o_done = done_a; o_err = err_a;
        end
    end

    logic [7:0] got_addr[$];
    logic [8:0] got_data[$];
    always @(negedge clk) begin
        if (o_wr_en) begin
            got_addr.push_back(o_addr);
            got_data.push_back(o_data);
        end
    end

    logic [7:0] stream[$];
    logic [7:0] exp_addr[$];
    logic [8:0] exp_data[$];
    logic       exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Words are byte pairs; stop on halt or a full memory; optional checksum byte follows halt.
    function automatic void model(input int rom);
        int         i      = 0;
        logic [7:0] x      = 8'h00;
        logic       halted = 1'b0;
        logic [8:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        while (i + 1 < stream.size() && !halted && exp_data.size() < rom) begin
            w = {stream[i+1][0], stream[i]};
            x = x ^ stream[i] ^ stream[i+1];
            exp_addr.push_back(8'(exp_data.size()));
            exp_data.push_back(w);
            halted = (w == halt);
            i += 2;
        end
        if (!halted) exp_err = 1'b1;
`ifdef CHECKSUM_EN
        else exp_err = (i >= stream.size()) || (stream[i] != x);
`endif
    endfunction

    task automatic gen(input int rom, input int len);
        logic [7:0] lo, hi, x;
        x = 8'h00;
        stream.delete();
        for (int k = 0; k < rom; k++) begin
            if (k == len) begin
                lo = 8'hC0;
                hi = 8'h01 | (8'($urandom) & 8'hFE);
            end else begin
                lo = 8'($urandom);
                hi = 8'($urandom);
            end
            stream.push_back(lo);
            stream.push_back(hi);
            x = x ^ lo ^ hi;
            if ({hi[0], lo} == halt) begin
`ifdef CHECKSUM_EN
                stream.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'h5A));
`endif
                break;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_wr_en"}, o_wr_en, 0);
        chk({tag, "_addr"},  o_addr,  0);
        chk({tag, "_data"},  o_data,  0);
        chk({tag, "_count"}, o_count, 0);
        chk({tag, "_busy"},  o_busy,  0);
        chk({tag, "_done"},  o_done,  0);
        chk({tag, "_error"}, o_err,   0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("byte_ready_wait", o_ready, 1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic s, input int gmin, input int gmax);
        int t = 0;
        sel = s;
        got_addr.delete();
        got_data.delete();
        @(posedge clk);
        #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_start_busy"},  o_busy,  1);
        chk({tag, "_start_done"},  o_done,  0);
        chk({tag, "_start_count"}, o_count, 0);
        foreach (stream[k]) send(stream[k], $urandom_range(gmin, gmax));
        @(negedge clk);
        while (!o_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_wait"}, o_done, 1);
        // hold valid high in DONE: nothing may be consumed or written
        byte_in    = 8'($urandom);
        byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        model(s ? 4 : 256);
        chk({tag, "_nwrites"}, got_data.size(), exp_data.size());
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            chk({tag, "_addr"}, got_addr[k], exp_addr[k]);
            chk({tag, "_data"}, got_data[k], exp_data[k]);
        end
        chk({tag, "_done"},  o_done,  1);
        chk({tag, "_busy"},  o_busy,  0);
        chk({tag, "_error"}, o_err,   exp_err);
        chk({tag, "_count"}, o_count, exp_data.size());
        chk({tag, "_ready"}, o_ready, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0; check_zero("reset_a");
        sel = 1'b1; check_zero("reset_b");
        reset_n = 1'b1;

        stream = '{8'h46, 8'h00, 8'hC0, 8'h01};
`ifdef CHECKSUM_EN
        stream.push_back(8'h87);
`endif
        run_load("single", 1'b0, 0, 0);
        chk("single_count2", o_count, 2);
        chk("single_err0", o_err, 0);

        run_load("stall", 1'b0, 1, 1);

`ifdef CHECKSUM_EN
        stream = '{8'h46, 8'h00, 8'hC0, 8'h01, 8'h00};
        run_load("csum_bad", 1'b0, 0, 1);
        chk("csum_bad_err1", o_err, 1);
`endif

        stream = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h01};
        run_load("overflow", 1'b1, 0, 1);
        chk("overflow_err1", o_err, 1);

        sel = 1'b0;
        @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        send(8'h46, 0);
        send(8'h00, 0);
        send(8'h12, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        reset_n = 1'b1;
        stream = '{8'h46, 8'h00, 8'hC0, 8'h01};
`ifdef CHECKSUM_EN
        stream.push_back(8'h87);
`endif
        run_load("reload", 1'b0, 0, 2);

        for (int r = 0; r < 12; r++) begin
            logic s;
            s = r[0];
            if (s) gen(4, $urandom_range(0, 5));
            else if (r == 10) gen(256, 300);
            else gen(256, $urandom_range(0, 12));
            run_load("rand", s, 0, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
